rdma_rx: RTL and testbench
==========================

Name: rdma_rx

Overview:
Receive-side counterpart of the RC transmit path. Takes the 64-bit beat stream from the link and parses the first beat of each packet as a header. Checks QP, opcode, length and PSN ordering, then forwards the payload of in-sequence packets to the consumer. Generates ACK/NAK requests for the transmit side and pulses rx_done on each good packet.

Parameters:
LOCAL_QP, 16'h0001, destination QP accepted by this receiver
INIT_PSN, 24'h000000, expected PSN after reset
MAX_LEN, 16'd256, max payload length in beats; larger is an invalid request

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rx_in_valid  in  1  input beat valid; no backpressure, a beat is consumed every valid cycle
rx_in_data  in  64  input beat
rx_in_last  in  1  last beat of packet
rx_out_valid  out  1  payload beat valid
rx_out_data  out  64  payload beat
rx_out_last  out  1  last payload beat
rx_done  out  1  one-cycle pulse, good packet complete
rx_err  out  1  one-cycle pulse, packet dropped or malformed
ack_valid  out  1  one-cycle pulse, ACK/NAK request
ack_psn  out  24  PSN carried in the ACK/NAK
ack_syndrome  out  2  00 ACK, 01 NAK sequence error, 10 NAK invalid request
exp_psn  out  24  current expected PSN

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (also mid-packet): state IDLE; exp_psn=INIT_PSN; beat counter 0; all other outputs 0. A packet in flight is abandoned with no pulses.
- Header layout: [63:56] opcode, [55:32] PSN, [31:16] dest QP, [15:0] len (payload beats).
- Supported opcodes: 0x04 SEND_ONLY, 0x0A WRITE_ONLY.
- Cycles with rx_in_valid=0 are ignored; state and counters hold.
- All outputs are registered. Payload beat out comes 1 cycle after the beat in. Pulses default to 0 each cycle.
- FSM states: IDLE (expect header), PAYLOAD, DROP (discard until rx_in_last).
- Header checks in IDLE, in priority order:
  1. QP != LOCAL_QP: silent drop; rx_err pulse; no ACK.
  2. Opcode unsupported, or len > MAX_LEN: NAK 10 with ack_psn=PSN; rx_err.
  3. PSN == exp_psn-1 mod 2^24 (duplicate): drop; ACK 00 with ack_psn=PSN; no rx_err.
  4. PSN != exp_psn: drop; NAK 01 with ack_psn=exp_psn; rx_err.
  5. Otherwise: accept.
- Header pulses (ack/err) occur 1 cycle after the header beat.
- Header-stage next state: a drop goes to DROP unless rx_in_last, else stays IDLE. An accepted header goes to PAYLOAD unless len==0.
- Header with rx_in_last=1:
  - Accepted and len==0: good packet with no payload beats; 1 cycle later rx_done and ACK 00 (ack_psn=PSN); exp_psn increments.
  - Accepted and len!=0: NAK 10; rx_err; exp_psn unchanged.
- Accepted header with len==0 but no last: NAK 10; rx_err; go to DROP.
- PAYLOAD:
  - Each beat is forwarded; cnt increments. rx_out_last = rx_in_last.
  - rx_in_last && cnt+1==len: rx_done plus ACK 00 (ack_psn=packet PSN) in the same cycle as rx_out_last. exp_psn <= exp_psn+1, wrapping 24'hFFFFFF to 0. Go to IDLE.
  - rx_in_last && cnt+1!=len (short): rx_err plus NAK 10 with rx_out_last; exp_psn unchanged; go to IDLE.
  - !rx_in_last && cnt+1==len (long): rx_out_last=1 on that beat and rx_err pulses. Go to DROP; remaining beats are not forwarded; no further pulse.
- DROP: beats discarded; on rx_in_last return to IDLE.
- Back-to-back: a header on the cycle after a last beat is handled normally.

Optional Feature:
RDMA_RX_STATS_EN:
- Defined: adds outputs stat_good_cnt[31:0] and stat_drop_cnt[31:0].
  - stat_good_cnt increments on each rx_done.
  - stat_drop_cnt increments on each rx_err.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then header {0x04, PSN 0, QP 1, len 3} plus 3 payload beats (last on 3rd) -> 3 beats out 1 cycle later; rx_done and ack_valid (00, psn 0) with rx_out_last; exp_psn=1.
- With exp_psn=5, send header PSN 7 len 1 -> no payload out; NAK 01 ack_psn=5; rx_err; exp_psn stays 5.
- With exp_psn=5, send PSN 4 -> ACK 00 ack_psn=4; no rx_err; no payload; exp_psn 5.
- QP 2 header, len 2 -> no output, rx_err only, no ack_valid.
- len 2 header, last on 1st payload beat -> 1 beat out with rx_out_last; rx_err plus NAK 10; exp_psn unchanged. len 1 with 3 payload beats -> 1 beat out with last; rx_err; remaining beats dropped.
- INIT_PSN=24'hFFFFFF, good packet -> exp_psn wraps to 0. Assert rst mid-payload -> outputs 0 next cycle; exp_psn=INIT_PSN; next header is parsed as new packet.

Source files
------------

// File: rtl/rdma_rx.sv
// rdma_rx: receive side of the RC path.
// Parses the first beat of each packet as a header and checks QP, opcode, length and PSN.
// Forwards the payload of in-sequence packets one cycle after it arrives.
// Raises ACK/NAK requests for the transmit side, plus rx_done/rx_err pulses.
// Optional feature: define RDMA_RX_STATS_EN to add the saturating counters
// stat_good_cnt and stat_drop_cnt.
module rdma_rx #(
  parameter logic [15:0] LOCAL_QP = 16'h0001,
  parameter logic [23:0] INIT_PSN = 24'h000000,
  parameter logic [15:0] MAX_LEN  = 16'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in_valid,
  input  logic [63:0] rx_in_data,
  input  logic        rx_in_last,
  output logic        rx_out_valid,
  output logic [63:0] rx_out_data,
  output logic        rx_out_last,
  output logic        rx_done,
  output logic        rx_err,
  output logic        ack_valid,
  output logic [23:0] ack_psn,
  output logic [1:0]  ack_syndrome,
  output logic [23:0] exp_psn
`ifdef RDMA_RX_STATS_EN
  ,
  output logic [31:0] stat_good_cnt,
  output logic [31:0] stat_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  localparam logic [7:0] OP_SEND_ONLY  = 8'h04;
  localparam logic [7:0] OP_WRITE_ONLY = 8'h0A;
  localparam logic [1:0] SYN_ACK       = 2'b00;
  localparam logic [1:0] SYN_NAK_SEQ   = 2'b01;
  localparam logic [1:0] SYN_NAK_INV   = 2'b10;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [23:0] psn_q, psn_d;
  logic [23:0] exp_d;

  logic        out_valid_d, out_last_d, done_d, err_d, ack_valid_d;
  logic [23:0] ack_psn_d;
  logic [1:0]  ack_syn_d;

  // Header fields, only meaningful while in ST_IDLE
  logic [7:0]  hdr_op;
  logic [23:0] hdr_psn;
  logic [15:0] hdr_qp;
  logic [15:0] hdr_len;
  logic        hdr_inv;
  logic [23:0] exp_prev;
  logic [15:0] cnt_inc;
  logic        at_len;
  state_t      drop_state;

  assign hdr_op     = rx_in_data[63:56];
  assign hdr_psn    = rx_in_data[55:32];
  assign hdr_qp     = rx_in_data[31:16];
  assign hdr_len    = rx_in_data[15:0];
  assign hdr_inv    = !(hdr_op == OP_SEND_ONLY || hdr_op == OP_WRITE_ONLY) || (hdr_len > MAX_LEN);
  assign exp_prev   = exp_psn - 24'd1;  // duplicate PSN, wraps modulo 2^24
  assign cnt_inc    = cnt_q + 16'd1;
  assign at_len     = (cnt_inc == len_q);
  assign drop_state = rx_in_last ? ST_IDLE : ST_DROP;

  // FSM state and packet context register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      psn_q   <= '0;
      exp_psn <= INIT_PSN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      psn_q   <= psn_d;
      exp_psn <= exp_d;
    end
  end

  // Next-state logic, header checks and next values of the registered outputs
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    psn_d       = psn_q;
    exp_d       = exp_psn;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ack_valid_d = 1'b0;
    ack_psn_d   = '0;
    ack_syn_d   = SYN_ACK;
    if (rx_in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_qp != LOCAL_QP) begin
            err_d   = 1'b1;
            state_d = drop_state;
          end else if (hdr_inv) begin
            ack_valid_d = 1'b1;
            ack_syn_d   = SYN_NAK_INV;
            ack_psn_d   = hdr_psn;
            err_d       = 1'b1;
            state_d     = drop_state;
          end else if (hdr_psn == exp_prev) begin
            ack_valid_d = 1'b1;
            ack_psn_d   = hdr_psn;
            state_d     = drop_state;
          end else if (hdr_psn != exp_psn) begin
            ack_valid_d = 1'b1;
            ack_syn_d   = SYN_NAK_SEQ;
            ack_psn_d   = exp_psn;
            err_d       = 1'b1;
            state_d     = drop_state;
          end else if (hdr_len == 16'd0 && rx_in_last) begin
            // Header-only packet: complete right away
            done_d      = 1'b1;
            ack_valid_d = 1'b1;
            ack_psn_d   = hdr_psn;
            exp_d       = exp_psn + 24'd1;
          end else if (hdr_len == 16'd0 || rx_in_last) begin
            // Length field disagrees with where the packet actually ends
            ack_valid_d = 1'b1;
            ack_syn_d   = SYN_NAK_INV;
            ack_psn_d   = hdr_psn;
            err_d       = 1'b1;
            state_d     = drop_state;
          end else begin
            state_d = ST_PAYLOAD;
            cnt_d   = '0;
            len_d   = hdr_len;
            psn_d   = hdr_psn;
          end
        end
        ST_PAYLOAD: begin
          out_valid_d = 1'b1;
          out_last_d  = rx_in_last | at_len;
          cnt_d       = cnt_inc;
          if (rx_in_last && at_len) begin
            done_d      = 1'b1;
            ack_valid_d = 1'b1;
            ack_psn_d   = psn_q;
            exp_d       = exp_psn + 24'd1;
            state_d     = ST_IDLE;
          end else if (rx_in_last) begin
            ack_valid_d = 1'b1;
            ack_syn_d   = SYN_NAK_INV;
            ack_psn_d   = psn_q;
            err_d       = 1'b1;
            state_d     = ST_IDLE;
          end else if (at_len) begin
            // Packet runs past its length: close the output here, discard the rest
            err_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (rx_in_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output registers: payload is one cycle behind its input beat, pulses last one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_out_valid <= 1'b0;
      rx_out_data  <= '0;
      rx_out_last  <= 1'b0;
      rx_done      <= 1'b0;
      rx_err       <= 1'b0;
      ack_valid    <= 1'b0;
      ack_psn      <= '0;
      ack_syndrome <= SYN_ACK;
    end else begin
      rx_out_valid <= out_valid_d;
      rx_out_data  <= out_valid_d ? rx_in_data : '0;
      rx_out_last  <= out_last_d;
      rx_done      <= done_d;
      rx_err       <= err_d;
      ack_valid    <= ack_valid_d;
      ack_psn      <= ack_psn_d;
      ack_syndrome <= ack_syn_d;
    end
  end

`ifdef RDMA_RX_STATS_EN
  // Saturating packet counters, advanced by the registered done/err pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good_cnt <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (rx_done && stat_good_cnt != '1) stat_good_cnt <= stat_good_cnt + 32'd1;
      if (rx_err && stat_drop_cnt != '1) stat_drop_cnt <= stat_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rdma_rx.sv
// tb_rdma_rx: self-checking bench for rdma_rx.
// Two instances share the input stream: one with INIT_PSN=0 and one with INIT_PSN=24'hFFFFFF.
// A packet-level model predicts every output cycle of both instances.
module tb_rdma_rx;

  localparam logic [15:0] LQP   = 16'h0001;
  localparam logic [23:0] INIT0 = 24'h000000;
  localparam logic [23:0] INIT1 = 24'hFFFFFF;
  localparam int          MAXL  = 256;

  typedef struct packed {
    logic        ov;
    logic [63:0] od;
    logic        ol;
    logic        done;
    logic        err;
    logic        av;
    logic [23:0] ap;
    logic [1:0]  syn;
    logic [23:0] ep;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_in_valid;
  logic [63:0] rx_in_data;
  logic        rx_in_last;

  logic        rx_out_valid0, rx_out_last0, rx_done0, rx_err0, ack_valid0;
  logic [63:0] rx_out_data0;
  logic [23:0] ack_psn0, exp_psn0;
  logic [1:0]  ack_syndrome0;
  logic        rx_out_valid1, rx_out_last1, rx_done1, rx_err1, ack_valid1;
  logic [63:0] rx_out_data1;
  logic [23:0] ack_psn1, exp_psn1;
  logic [1:0]  ack_syndrome1;

  rdma_rx #(.LOCAL_QP(LQP), .INIT_PSN(INIT0), .MAX_LEN(16'd256)) dut0 (
    .clk(clk), .rst(rst), .rx_in_valid(rx_in_valid), .rx_in_data(rx_in_data),
    .rx_in_last(rx_in_last), .rx_out_valid(rx_out_valid0), .rx_out_data(rx_out_data0),
    .rx_out_last(rx_out_last0), .rx_done(rx_done0), .rx_err(rx_err0),
    .ack_valid(ack_valid0), .ack_psn(ack_psn0), .ack_syndrome(ack_syndrome0),
    .exp_psn(exp_psn0)
  );

  rdma_rx #(.LOCAL_QP(LQP), .INIT_PSN(INIT1), .MAX_LEN(16'd256)) dut1 (
    .clk(clk), .rst(rst), .rx_in_valid(rx_in_valid), .rx_in_data(rx_in_data),
    .rx_in_last(rx_in_last), .rx_out_valid(rx_out_valid1), .rx_out_data(rx_out_data1),
    .rx_out_last(rx_out_last1), .rx_done(rx_done1), .rx_err(rx_err1),
    .ack_valid(ack_valid1), .ack_psn(ack_psn1), .ack_syndrome(ack_syndrome1),
    .exp_psn(exp_psn1)
  );

  always #5 clk = ~clk;

  obs_t        q0[$];
  obs_t        q1[$];
  logic [63:0] pk[$];        // current packet: header then payload beats
  logic [23:0] cur_ep[2];    // model's expected PSN per instance
  int          n_checks = 0;
  int          n_errors = 0;
  obs_t        exp_o, act_o;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  // Payload data and ACK fields are only meaningful when their valid bit is set
  function automatic obs_t mask(input obs_t o);
    obs_t r;
    r = o;
    if (!r.ov) r.od = '0;
    if (!r.av) begin
      r.ap  = '0;
      r.syn = '0;
    end
    return r;
  endfunction

  // Expected outputs one cycle after beat k of pk, given the expected PSN e at packet start
  function automatic obs_t model_beat(input logic [23:0] e, input int k);
    logic [63:0] h;
    logic [7:0]  op;
    logic [23:0] psn;
    logic [15:0] qp;
    int          len, nb;
    bit          inv, acc;
    obs_t        r;
    h   = pk[0];
    op  = h[63:56];
    psn = h[55:32];
    qp  = h[31:16];
    len = int'(h[15:0]);
    nb  = pk.size() - 1;
    r    = '0;
    r.ep = e;
    inv  = !(op == 8'h04 || op == 8'h0A) || (len > MAXL);
    acc  = (qp == LQP) && !inv && (psn == e);
    if (k == 0) begin
      if (qp != LQP) r.err = 1'b1;
      else if (inv) begin
        r.av = 1'b1; r.syn = 2'd2; r.ap = psn; r.err = 1'b1;
      end else if (psn == e - 24'd1) begin
        r.av = 1'b1; r.ap = psn;
      end else if (psn != e) begin
        r.av = 1'b1; r.syn = 2'd1; r.ap = e; r.err = 1'b1;
      end else if (len == 0 && nb == 0) begin
        r.done = 1'b1; r.av = 1'b1; r.ap = psn; r.ep = e + 24'd1;
      end else if (len == 0 || nb == 0) begin
        r.av = 1'b1; r.syn = 2'd2; r.ap = psn; r.err = 1'b1;
      end
    end else if (acc && len != 0 && k <= len) begin
      r.ov = 1'b1;
      r.od = pk[k];
      r.ol = (k == nb) || (k == len);
      if (k == nb && k == len) begin
        r.done = 1'b1; r.av = 1'b1; r.ap = psn; r.ep = e + 24'd1;
      end else if (k == nb) begin
        r.err = 1'b1; r.av = 1'b1; r.syn = 2'd2; r.ap = psn;
      end else if (k == len) begin
        r.err = 1'b1;
      end
    end
    return r;
  endfunction

  // Compare process: every cycle that has a prediction queued, check both instances
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      exp_o = q0.pop_front();
      act_o = {rx_out_valid0, rx_out_data0, rx_out_last0, rx_done0, rx_err0,
               ack_valid0, ack_psn0, ack_syndrome0, exp_psn0};
      check("dut0_cycle", mask(act_o), mask(exp_o));
    end
    if (q1.size() > 0) begin
      exp_o = q1.pop_front();
      act_o = {rx_out_valid1, rx_out_data1, rx_out_last1, rx_done1, rx_err1,
               ack_valid1, ack_psn1, ack_syndrome1, exp_psn1};
      check("dut1_cycle", mask(act_o), mask(exp_o));
    end
  end

  function automatic logic [63:0] mk_hdr(input logic [7:0] op, input logic [23:0] psn,
                                         input logic [15:0] qp, input logic [15:0] len);
    return {op, psn, qp, len};
  endfunction

  task automatic drive(input logic r, input logic v, input logic [63:0] d, input logic l);
    rst         = r;
    rx_in_valid = v;
    rx_in_data  = d;
    rx_in_last  = l;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    obs_t o;
    o = '0; o.ep = cur_ep[0]; q0.push_back(o);
    o = '0; o.ep = cur_ep[1]; q1.push_back(o);
    drive(1'b0, 1'b0, {$urandom, $urandom}, 1'($urandom_range(1)));
  endtask

  task automatic reset_cycle(input logic v);
    obs_t o;
    cur_ep[0] = INIT0;
    cur_ep[1] = INIT1;
    o = '0; o.ep = INIT0; q0.push_back(o);
    o = '0; o.ep = INIT1; q1.push_back(o);
    drive(1'b1, v, {$urandom, $urandom}, 1'($urandom_range(1)));
  endtask

  // Send header plus nb payload beats (last on the final one); reset instead of beat abort_at
  task automatic run_packet(input logic [63:0] hdr, input int nb, input int gap_pct, input int abort_at);
    logic [23:0] e0, e1;
    obs_t        o;
    pk.delete();
    pk.push_back(hdr);
    for (int i = 0; i < nb; i++) pk.push_back({$urandom, $urandom});
    e0 = cur_ep[0];
    e1 = cur_ep[1];
    for (int k = 0; k <= nb; k++) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) idle_cycle();
      if (k == abort_at) begin
        reset_cycle(1'b1);
        return;
      end
      o = model_beat(e0, k); q0.push_back(o); cur_ep[0] = o.ep;
      o = model_beat(e1, k); q1.push_back(o); cur_ep[1] = o.ep;
      drive(1'b0, 1'b1, pk[k], k == nb);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t        r;
    logic [23:0] psn, base;
    logic [15:0] qp, len;
    logic [7:0]  op;
    int          nb, ab, sel;

    reset_cycle(1'b0);
    reset_cycle(1'b1);
    check("rst_exp0", exp_psn0, INIT0);
    check("rst_exp1", exp_psn1, INIT1);
    check("rst_quiet", {rx_out_valid0, rx_done0, rx_err0, ack_valid0, rx_out_valid1}, 5'b0);

    // PSN 0xFFFFFF: duplicate for instance 0, in-sequence for instance 1 (wraps to 0)
    run_packet(mk_hdr(8'h04, 24'hFFFFFF, LQP, 16'd1), 1, 0, -1);
    check("wrap_exp1", exp_psn1, 24'h000000);
    check("dup_exp0", exp_psn0, 24'h000000);

    // Basic good packet of three beats
    run_packet(mk_hdr(8'h04, 24'd0, LQP, 16'd3), 3, 0, -1);
    check("good_exp0", exp_psn0, 24'd1);

    for (int p = 1; p <= 4; p++) begin
      len = 16'($urandom_range(3));
      run_packet(mk_hdr(8'h0A, 24'(p), LQP, len), int'(len), 20, -1);
    end
    check("exp5", exp_psn0, 24'd5);

    // Pin the model on the out-of-sequence and duplicate rules with hand-computed values
    pk.delete(); pk.push_back(mk_hdr(8'h0A, 24'd7, LQP, 16'd1)); pk.push_back(64'd0);
    r = model_beat(24'd5, 0);
    check("pin_nak_seq", {r.av, r.syn, r.ap, r.err, r.ep}, {1'b1, 2'b01, 24'd5, 1'b1, 24'd5});
    pk.delete(); pk.push_back(mk_hdr(8'h04, 24'd4, LQP, 16'd1)); pk.push_back(64'd0);
    r = model_beat(24'd5, 0);
    check("pin_dup", {r.av, r.syn, r.ap, r.err}, {1'b1, 2'b00, 24'd4, 1'b0});

    run_packet(mk_hdr(8'h0A, 24'd7, LQP, 16'd1), 1, 0, -1);      // NAK 01, ack_psn 5
    run_packet(mk_hdr(8'h04, 24'd4, LQP, 16'd1), 1, 0, -1);      // duplicate, ACK 00
    run_packet(mk_hdr(8'h04, 24'd5, 16'h0002, 16'd2), 2, 0, -1); // wrong QP
    run_packet(mk_hdr(8'h04, 24'd5, LQP, 16'd2), 1, 0, -1);      // short
    run_packet(mk_hdr(8'h04, 24'd5, LQP, 16'd1), 3, 0, -1);      // long
    check("exp_hold5", exp_psn0, 24'd5);
    run_packet(mk_hdr(8'h0A, 24'd5, LQP, 16'd0), 0, 0, -1);      // header-only good
    check("exp6", exp_psn0, 24'd6);
    run_packet(mk_hdr(8'h04, 24'd6, LQP, 16'd0), 2, 0, -1);      // len 0 but payload
    run_packet(mk_hdr(8'h04, 24'd6, LQP, 16'd4), 0, 0, -1);      // last on header, len 4
    run_packet(mk_hdr(8'h05, 24'd6, LQP, 16'd2), 2, 0, -1);      // unsupported opcode
    run_packet(mk_hdr(8'h04, 24'd6, LQP, 16'd257), 2, 0, -1);    // over MAX_LEN
    run_packet(mk_hdr(8'h04, 24'd6, LQP, 16'd256), 256, 10, -1); // exactly MAX_LEN
    check("exp7", exp_psn0, 24'd7);
    run_packet(mk_hdr(8'h04, 24'd7, LQP, 16'd1), 1, 0, -1);      // back-to-back
    run_packet(mk_hdr(8'h0A, 24'd8, LQP, 16'd2), 2, 0, -1);
    check("exp9", exp_psn0, 24'd9);

    // Reset in the middle of a payload, then a fresh packet
    run_packet(mk_hdr(8'h04, 24'd9, LQP, 16'd4), 4, 0, 2);
    check("mid_rst_exp0", exp_psn0, INIT0);
    check("mid_rst_exp1", exp_psn1, INIT1);
    check("mid_rst_quiet", {rx_out_valid0, rx_out_last0, rx_done0, rx_err0, ack_valid0}, 5'b0);
    run_packet(mk_hdr(8'h04, 24'd0, LQP, 16'd2), 2, 0, -1);
    check("post_rst_exp0", exp_psn0, 24'd1);

    // Randomized traffic
    for (int p = 0; p < 400; p++) begin
      base = cur_ep[$urandom_range(1)];
      sel  = $urandom_range(99);
      if (sel < 70)      psn = base;
      else if (sel < 80) psn = base - 24'd1;
      else if (sel < 90) psn = base + 24'd1;
      else               psn = 24'($urandom);
      qp = ($urandom_range(99) < 92) ? LQP : 16'($urandom);
      sel = $urandom_range(99);
      if (sel < 45)      op = 8'h04;
      else if (sel < 90) op = 8'h0A;
      else               op = 8'($urandom);
      sel = $urandom_range(99);
      if (sel < 85)      len = 16'($urandom_range(6));
      else if (sel < 89) len = 16'd255;
      else if (sel < 93) len = 16'd256;
      else if (sel < 96) len = 16'd257;
      else               len = 16'($urandom);
      sel = $urandom_range(99);
      if (len <= 16'd300 && sel < 70)      nb = int'(len);
      else if (len <= 16'd300 && sel < 80) nb = int'(len) + 1;
      else if (len != 16'd0 && len <= 16'd300 && sel < 88) nb = int'(len) - 1;
      else                                  nb = $urandom_range(8);
      ab = ($urandom_range(99) < 3) ? $urandom_range(nb) : -1;
      run_packet(mk_hdr(op, psn, qp, len), nb, 25, ab);
    end

    for (int i = 0; i < 3; i++) idle_cycle();
    check("drain0", 32'(q0.size()), 32'd0);
    check("drain1", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
